// File: rtl/sram_mem_ctrl.sv
// Single-port SRAM sequencer: optional data access, then instruction fetch, then a one-cycle DONE.
// Optional one-entry fetch buffer is enabled by defining SRAM_CTRL_FETCH_BUF_EN.
module sram_mem_ctrl #(
  parameter int WAIT_CYCLES = 2,
  parameter int ADDR_BITS   = 20
) (
  input  logic                 clk_50M,
  input  logic                 reset_btn,
  input  logic [31:0]          pc_in,
  output logic [31:0]          instruction,
  input  logic [31:0]          mem_addr,
  input  logic [31:0]          mem_wdata,
  input  logic [4:0]           mem_ctrl_signal,
  output logic [31:0]          mem_rdata,
  output logic                 mem_stall,
  output logic [ADDR_BITS-1:0] ram_addr,
  output logic [31:0]          ram_data_o,
  input  logic [31:0]          ram_data_i,
  output logic                 ram_data_oe,
  output logic [3:0]           ram_be_n,
  output logic                 ram_ce_n,
  output logic                 ram_oe_n,
  output logic                 ram_we_n
);

  typedef enum logic [1:0] {IDLE, DATA, FETCH, DONE} state_t;

  state_t                 state;
  state_t                 state_nxt;
  logic [3:0]             wait_cnt;
  logic                   last_cyc;

  logic [ADDR_BITS-1:0]   pc_word_q;
  logic [ADDR_BITS-1:0]   addr_word_q;
  logic [1:0]             off_q;
  logic [31:0]            wdata_q;
  logic [4:0]             ctrl_q;

  logic                   req_data;
  logic                   req_wr;
  logic                   wr_q;
  logic                   buf_hit_in;
  logic                   buf_hit_q;

  logic [3:0]             wr_be_n;
  logic [31:0]            wr_lanes;
  logic [7:0]             ld_byte;
  logic [15:0]            ld_half;
  logic [31:0]            ld_val;

  logic                   unused_in;

  assign req_wr    = mem_ctrl_signal[3];
  assign req_data  = mem_ctrl_signal[4] | mem_ctrl_signal[3];
  assign wr_q      = ctrl_q[3];
  assign last_cyc  = (wait_cnt == 4'(WAIT_CYCLES - 1));
  assign unused_in = ^{pc_in[31:ADDR_BITS+2], pc_in[1:0], mem_addr[31:ADDR_BITS+2]};

`ifdef SRAM_CTRL_FETCH_BUF_EN
  logic                 buf_vld;
  logic [ADDR_BITS-1:0] buf_addr;
  logic [31:0]          buf_dat;
  logic                 fetch_skip;

  assign buf_hit_in = buf_vld && (buf_addr == pc_in[ADDR_BITS+1:2]);
  assign buf_hit_q  = buf_vld && (buf_addr == pc_word_q);
  assign fetch_skip = (state_nxt == DONE) && (state != FETCH);

  // A write leaving IDLE invalidates before the DATA-end hit check sees buf_vld.
  always_ff @(posedge clk_50M) begin
    if (reset_btn) begin
      buf_vld  <= 1'b0;
      buf_addr <= '0;
      buf_dat  <= '0;
    end else if (state == FETCH && last_cyc) begin
      buf_vld  <= 1'b1;
      buf_addr <= pc_word_q;
      buf_dat  <= ram_data_i;
    end else if (state == IDLE && req_wr && buf_vld &&
                 buf_addr == mem_addr[ADDR_BITS+1:2]) begin
      buf_vld  <= 1'b0;
    end
  end
`else
  assign buf_hit_in = 1'b0;
  assign buf_hit_q  = 1'b0;
`endif

  always_ff @(posedge clk_50M) begin
    if (reset_btn) begin
      state    <= IDLE;
      wait_cnt <= '0;
    end else begin
      state <= state_nxt;
      if ((state == DATA || state == FETCH) && !last_cyc)
        wait_cnt <= wait_cnt + 4'd1;
      else
        wait_cnt <= '0;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (req_data)        state_nxt = DATA;
        else if (buf_hit_in) state_nxt = DONE;
        else                 state_nxt = FETCH;
      end
      DATA:    if (last_cyc) state_nxt = buf_hit_q ? DONE : FETCH;
      FETCH:   if (last_cyc) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Request is latched every IDLE cycle; the core's inputs are ignored once stalled.
  always_ff @(posedge clk_50M) begin
    if (reset_btn) begin
      pc_word_q   <= '0;
      addr_word_q <= '0;
      off_q       <= '0;
      wdata_q     <= '0;
      ctrl_q      <= '0;
    end else if (state == IDLE) begin
      pc_word_q   <= pc_in[ADDR_BITS+1:2];
      addr_word_q <= mem_addr[ADDR_BITS+1:2];
      off_q       <= mem_addr[1:0];
      wdata_q     <= mem_wdata;
      ctrl_q      <= mem_ctrl_signal;
    end
  end

  always_comb begin
    case (ctrl_q[1:0])
      2'b00: begin
        wr_be_n  = ~(4'b0001 << off_q);
        wr_lanes = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        wr_be_n  = off_q[1] ? 4'b0011 : 4'b1100;
        wr_lanes = {2{wdata_q[15:0]}};
      end
      default: begin
        wr_be_n  = 4'b0000;
        wr_lanes = wdata_q;
      end
    endcase
  end

  always_comb begin
    ld_byte = ram_data_i[8*off_q +: 8];
    ld_half = ram_data_i[16*off_q[1] +: 16];
    case (ctrl_q[1:0])
      2'b00:   ld_val = {{24{ctrl_q[2] & ld_byte[7]}}, ld_byte};
      2'b01:   ld_val = {{16{ctrl_q[2] & ld_half[15]}}, ld_half};
      default: ld_val = ram_data_i;
    endcase
  end

  always_comb begin
    ram_ce_n    = 1'b1;
    ram_oe_n    = 1'b1;
    ram_we_n    = 1'b1;
    ram_be_n    = 4'hF;
    ram_data_oe = 1'b0;
    ram_addr    = '0;
    ram_data_o  = '0;
    case (state)
      DATA: begin
        ram_ce_n = 1'b0;
        ram_addr = addr_word_q;
        if (wr_q) begin
          ram_data_oe = 1'b1;
          ram_we_n    = (wait_cnt == 4'd0);
          ram_be_n    = wr_be_n;
          ram_data_o  = wr_lanes;
        end else begin
          ram_oe_n = 1'b0;
          ram_be_n = 4'h0;
        end
      end
      FETCH: begin
        ram_ce_n = 1'b0;
        ram_oe_n = 1'b0;
        ram_be_n = 4'h0;
        ram_addr = pc_word_q;
      end
      default: ;
    endcase
  end

  assign mem_stall = ~reset_btn & (state != DONE);

  always_ff @(posedge clk_50M) begin
    if (reset_btn) begin
      instruction <= '0;
      mem_rdata   <= '0;
    end else begin
      if (state == DATA && last_cyc)
        mem_rdata <= wr_q ? 32'h0 : ld_val;
      if (state == FETCH && last_cyc)
        instruction <= ram_data_i;
`ifdef SRAM_CTRL_FETCH_BUF_EN
      if (fetch_skip)
        instruction <= buf_dat;
`endif
    end
  end

endmodule

// File: tb/tb_sram_mem_ctrl.sv
// Bench for sram_mem_ctrl: SRAM device model plus a transaction-level reference of the controller.
`timescale 1ns/1ps
module tb_sram_mem_ctrl;
  localparam int W  = 2;
  localparam int AB = 20;

  logic          clk_50M = 1'b0;
  logic          reset_btn = 1'b1;
  logic [31:0]   pc_in = '0, mem_addr = '0, mem_wdata = '0;
  logic [4:0]    mem_ctrl_signal = '0;
  logic [31:0]   instruction, mem_rdata, ram_data_o, ram_data_i;
  logic          mem_stall, ram_data_oe, ram_ce_n, ram_oe_n, ram_we_n;
  logic [AB-1:0] ram_addr;
  logic [3:0]    ram_be_n;

  sram_mem_ctrl #(.WAIT_CYCLES(W), .ADDR_BITS(AB)) dut (
    .clk_50M(clk_50M), .reset_btn(reset_btn), .pc_in(pc_in), .instruction(instruction),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ctrl_signal(mem_ctrl_signal),
    .mem_rdata(mem_rdata), .mem_stall(mem_stall), .ram_addr(ram_addr), .ram_data_o(ram_data_o),
    .ram_data_i(ram_data_i), .ram_data_oe(ram_data_oe), .ram_be_n(ram_be_n),
    .ram_ce_n(ram_ce_n), .ram_oe_n(ram_oe_n), .ram_we_n(ram_we_n));

  always #10 clk_50M = ~clk_50M;

  // SRAM device: 256 words, reads only while selected and output-enabled.
  logic [31:0] sram    [256];
  logic [31:0] ref_mem [256];
  assign ram_data_i = (!ram_ce_n && !ram_oe_n && !ram_data_oe) ? sram[ram_addr[7:0]] : 32'hA5A5_5A5A;

  always @(negedge clk_50M)
    if (!ram_ce_n && !ram_we_n)
      for (int l = 0; l < 4; l++)
        if (!ram_be_n[l]) sram[ram_addr[7:0]][8*l +: 8] = ram_data_o[8*l +: 8];

  int checks = 0;
  int errors = 0;

  // Reference state of the controller as seen by the core
  logic [31:0] m_rdata = '0;
  logic [31:0] m_instr;
  logic        mb_vld = 1'b0;
  logic [7:0]  mb_idx = '0;
  logic [31:0] mb_dat = '0;

  // Per-cycle record of the last transaction, for literal checks
  logic        cyc_stall [16];
  logic        cyc_oe    [16];
  logic        cyc_we    [16];
  logic [3:0]  cyc_be    [16];
  logic [19:0] cyc_addr  [16];
  logic [31:0] cyc_wd    [16];
  int          n_last;
  logic [31:0] got_instr, got_rdata;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic run_txn(input logic [31:0] pc, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [4:0] ctrl, input bit scramble);
    logic wr, rd, hit, sgn;
    logic [1:0] o, sz;
    logic [7:0] idx, b;
    logic [15:0] h;
    logic [31:0] w;
    int n, we_low, doe_cnt, oe_low, conflict;
    wr = ctrl[3]; rd = ctrl[4] && !ctrl[3]; sgn = ctrl[2]; sz = ctrl[1:0];
    o = addr[1:0]; idx = addr[9:2];
    if (wr) begin
      for (int l = 0; l < 4; l++) begin
        if (sz == 2'b00) begin
          if (l == int'(o)) ref_mem[idx][8*l +: 8] = wdata[7:0];
        end else if (sz == 2'b01) begin
          if ((l / 2) == int'(o[1])) ref_mem[idx][8*l +: 8] = wdata[8*(l%2) +: 8];
        end else begin
          ref_mem[idx][8*l +: 8] = wdata[8*l +: 8];
        end
      end
      m_rdata = 32'h0;
    end else if (rd) begin
      w = ref_mem[idx];
      b = w[8*o +: 8];
      h = w[16*o[1] +: 16];
      if (sz == 2'b00)      m_rdata = sgn ? {{24{b[7]}}, b} : {24'h0, b};
      else if (sz == 2'b01) m_rdata = sgn ? {{16{h[15]}}, h} : {16'h0, h};
      else                  m_rdata = w;
    end
    hit = 1'b0;
`ifdef SRAM_CTRL_FETCH_BUF_EN
    if (wr && mb_vld && mb_idx == idx) mb_vld = 1'b0;
    hit = mb_vld && (mb_idx == pc[9:2]);
    if (hit) m_instr = mb_dat;
    else begin
      m_instr = ref_mem[pc[9:2]];
      mb_vld = 1'b1; mb_idx = pc[9:2]; mb_dat = m_instr;
    end
`else
    m_instr = ref_mem[pc[9:2]];
`endif
    n = 2 + ((wr || rd) ? W : 0) + (hit ? 0 : W);
    n_last = n;
    pc_in = pc; mem_addr = addr; mem_wdata = wdata; mem_ctrl_signal = ctrl;
    we_low = 0; doe_cnt = 0; oe_low = 0; conflict = 0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk_50M);
      cyc_stall[k] = mem_stall; cyc_oe[k] = ram_oe_n; cyc_we[k] = ram_we_n;
      cyc_be[k] = ram_be_n; cyc_addr[k] = ram_addr; cyc_wd[k] = ram_data_o;
      chk($sformatf("stall_c%0d", k), 32'(mem_stall), 32'(k != n - 1));
      if (!ram_we_n) we_low++;
      if (ram_data_oe) doe_cnt++;
      if (!ram_oe_n) oe_low++;
      if (ram_data_oe && !ram_oe_n) conflict++;
      if (wr && k == 1) chk("we_setup", 32'(ram_we_n), 32'h1);
      if (k == n - 1) begin
        got_instr = instruction; got_rdata = mem_rdata;
        chk("instruction", instruction, m_instr);
        chk("mem_rdata", mem_rdata, m_rdata);
      end
      @(posedge clk_50M); #1;
      if (scramble && k == 0) begin
        pc_in = $urandom; mem_addr = $urandom; mem_wdata = $urandom;
        mem_ctrl_signal = 5'($urandom);
      end
    end
    chk("we_low_cycles", 32'(we_low), wr ? 32'(W - 1) : 32'h0);
    chk("data_oe_cycles", 32'(doe_cnt), wr ? 32'(W) : 32'h0);
    chk("oe_low_cycles", 32'(oe_low), 32'((rd ? W : 0) + (hit ? 0 : W)));
    chk("bus_conflict", 32'(conflict), 32'h0);
  endtask

  initial begin
    logic [31:0] pc, lastpc, addr;
    logic [4:0]  ctrl;
    logic [1:0]  op;
    for (int i = 0; i < 256; i++) begin
      sram[i] = $urandom; ref_mem[i] = sram[i];
    end
    sram[0] = 32'h3401_0002;     ref_mem[0] = 32'h3401_0002;
    sram[8'h40] = 32'h80FF_0000; ref_mem[8'h40] = 32'h80FF_0000;

    // Reset values, sampled while reset is still asserted
    repeat (2) @(posedge clk_50M);
    @(negedge clk_50M);
    chk("rst_stall", 32'(mem_stall), 32'h0);
    chk("rst_strobes", {29'h0, ram_ce_n, ram_oe_n, ram_we_n}, 32'h7);
    chk("rst_be_n", 32'(ram_be_n), 32'hF);
    chk("rst_data_oe", 32'(ram_data_oe), 32'h0);
    chk("rst_ram_addr", 32'(ram_addr), 32'h0);
    chk("rst_instr", instruction, 32'h0);
    chk("rst_rdata", mem_rdata, 32'h0);
    @(posedge clk_50M); #1;
    reset_btn = 1'b0;

    // Fetch-only at pc 0
    run_txn(32'h0, 32'h0, 32'h0, 5'b00000, 1'b0);
    chk("fetch_latency", 32'(n_last), 32'd4);
    chk("fetch_stall_seq", {28'h0, cyc_stall[0], cyc_stall[1], cyc_stall[2], cyc_stall[3]}, 32'hE);
    chk("fetch_instr_lit", got_instr, 32'h3401_0002);
    chk("fetch_addr", 32'(cyc_addr[1]), 32'h0);
    chk("fetch_oe_n", {30'h0, cyc_oe[1], cyc_oe[2]}, 32'h0);

    // Signed byte load then unsigned half load from word 0x80FF_0000
    run_txn(32'h4, 32'h103, 32'h0, 5'b10100, 1'b0);
    chk("lb_latency", 32'(n_last), 32'd6);
    chk("lb_lit", got_rdata, 32'hFFFF_FF80);
    run_txn(32'h8, 32'h102, 32'h0, 5'b10001, 1'b0);
    chk("lhu_latency", 32'(n_last), 32'd6);
    chk("lhu_lit", got_rdata, 32'h0000_80FF);

    // Half store of 0xBEEF at byte address 0x202
    run_txn(32'hC, 32'h202, 32'h0000_BEEF, 5'b01001, 1'b0);
    chk("sh_addr", 32'(cyc_addr[2]), 32'h80);
    chk("sh_be_n", 32'(cyc_be[2]), 32'h3);
    chk("sh_wdata", cyc_wd[2], 32'hBEEF_BEEF);
    chk("sh_we_seq", {30'h0, cyc_we[1], cyc_we[2]}, 32'h2);
    chk("sh_rdata_zero", got_rdata, 32'h0);

    // Reset in the first DATA cycle of a store: aborted before any write strobe
    pc_in = 32'h10; mem_addr = 32'h44; mem_wdata = 32'h1234_5678; mem_ctrl_signal = 5'b01010;
    @(posedge clk_50M); #1;
    reset_btn = 1'b1;
    @(posedge clk_50M); #1;
    chk("abort_strobes", {29'h0, ram_ce_n, ram_oe_n, ram_we_n}, 32'h7);
    chk("abort_data_oe", 32'(ram_data_oe), 32'h0);
    chk("abort_stall", 32'(mem_stall), 32'h0);
    chk("abort_be_n", 32'(ram_be_n), 32'hF);
    m_rdata = 32'h0; mb_vld = 1'b0;
    @(posedge clk_50M); #1;
    reset_btn = 1'b0;
    run_txn(32'h10, 32'h0, 32'h0, 5'b00000, 1'b0);
    chk("after_abort_latency", 32'(n_last), 32'd4);

    // Randomized traffic, core inputs scrambled while stalled
    lastpc = 32'h0;
    for (int t = 0; t < 200; t++) begin
      pc   = ($urandom_range(0, 9) < 3) ? lastpc : {22'h0, 8'($urandom), 2'b00};
      addr = 32'($urandom_range(0, 1023));
      op   = 2'($urandom);
      ctrl = {op, 1'($urandom), 2'($urandom)};
      run_txn(pc, addr, $urandom, ctrl, 1'b1);
      lastpc = pc;
    end

    for (int i = 0; i < 256; i++)
      chk($sformatf("sram_word_%0d", i), sram[i], ref_mem[i]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
